// File: rtl/score_counter_bcd.sv
`default_nettype none
// ============================================================================
// Module      : score_counter_bcd
// Description : Multi-digit BCD up/down score counter with rising-edge point
//               inputs, wrap or saturate boundaries, win lock, carry/borrow
//               chaining pulses and active-low 7-segment decode per digit.
//
// Parameters  : DIGITS    - number of BCD digits (1..6)
//               WRAP      - 1 = modulo 10^DIGITS, 0 = saturate at 0 and max
//               WIN_SCORE - decimal score that locks the counter (0 = off)
//               BLANK_LZ  - 1 = blank leading-zero digits (digit 0 always on)
//
// Ports       : clk        - system clock, rising edge
//               Reset_n    - asynchronous active-low reset
//               clear      - synchronous clear (edge detectors keep sampling)
//               inc_pos    - level input, each 0->1 requests +1
//               inc_neg    - level input, each 0->1 requests -1
//               count      - BCD score, digit 0 in [3:0]
//               hex        - active-low {g,f,e,d,c,b,a} per digit, digit 0 in [6:0]
//               carry_out  - one-cycle pulse on wrap max -> 0
//               borrow_out - one-cycle pulse on wrap 0 -> max
//               at_zero    - count == 0
//               at_max     - count == 10^DIGITS-1
//               win        - high while locked at WIN_SCORE
//
// Revision    : 1.0 - initial release
// ============================================================================
module score_counter_bcd #(
    parameter int DIGITS    = 2,
    parameter int WRAP      = 1,
    parameter int WIN_SCORE = 7,
    parameter int BLANK_LZ  = 0
) (
    input  logic                  clk,
    input  logic                  Reset_n,
    input  logic                  clear,
    input  logic                  inc_pos,
    input  logic                  inc_neg,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  carry_out,
    output logic                  borrow_out,
    output logic                  at_zero,
    output logic                  at_max,
    output logic                  win
);

    typedef enum logic [0:0] {
        ST_COUNT  = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Convert the decimal win score into the BCD layout of the count register
    // so the lock compare works directly on digits.
    function automatic logic [4*DIGITS-1:0] f_to_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned         x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    localparam logic [4*DIGITS-1:0] c_WIN_BCD = f_to_bcd(WIN_SCORE);
    localparam bit                  c_WIN_EN  = (WIN_SCORE != 0);
    localparam bit                  c_WRAP    = (WRAP != 0);
    localparam bit                  c_BLANK   = (BLANK_LZ != 0);

    // Registered state
    state_t              r_state;
    logic [4*DIGITS-1:0] r_count;
    logic                r_pos_prev;
    logic                r_neg_prev;
    logic                r_carry;
    logic                r_borrow;

    // Combinational
    logic                w_rise_p;
    logic                w_rise_n;
    logic                w_up;
    logic                w_down;
    logic [4*DIGITS-1:0] w_inc_val;
    logic [4*DIGITS-1:0] w_dec_val;
    logic                w_cy;
    logic                w_bw;
    logic                w_zero_hi;
    state_t              w_next_state;
    logic [4*DIGITS-1:0] w_next_count;
    logic                w_carry_nxt;
    logic                w_borrow_nxt;

    // Rising-edge detection; simultaneous edges cancel to HOLD.
    assign w_rise_p = inc_pos & ~r_pos_prev;
    assign w_rise_n = inc_neg & ~r_neg_prev;
    assign w_up     = w_rise_p & ~w_rise_n;
    assign w_down   = w_rise_n & ~w_rise_p;

    // Per-digit BCD ripple for +1 and -1. The ripple flag that survives past
    // the top digit means every digit was 9 (increment) or 0 (decrement),
    // which doubles as the at_max / at_zero detect. Incrementing max yields
    // all zeros and decrementing zero yields all nines, i.e. the wrap values.
    always_comb begin
        w_inc_val = r_count;
        w_dec_val = r_count;
        w_cy      = 1'b1;
        w_bw      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_cy) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_inc_val[4*i +: 4] = 4'd0;
                end else begin
                    w_inc_val[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_cy                = 1'b0;
                end
            end
            if (w_bw) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_dec_val[4*i +: 4] = 4'd9;
                end else begin
                    w_dec_val[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    w_bw                = 1'b0;
                end
            end
        end
    end

    assign at_max  = w_cy;
    assign at_zero = w_bw;

    // Display decode. Scanning from the top digit down, w_zero_hi stays set
    // while the current digit and every digit above it are zero.
    always_comb begin
        hex       = '0;
        w_zero_hi = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_hi = w_zero_hi & (r_count[4*i +: 4] == 4'd0);
            if (c_BLANK && (i != 0) && w_zero_hi) begin
                hex[7*i +: 7] = 7'b1111111;
            end else begin
                hex[7*i +: 7] = f_seg(r_count[4*i +: 4]);
            end
        end
    end

    // Next-state / next-count logic
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_carry_nxt  = 1'b0;
        w_borrow_nxt = 1'b0;
        case (r_state)
            ST_COUNT: begin
                if (w_up) begin
                    if (!at_max || c_WRAP) begin
                        w_next_count = w_inc_val;
                    end
                    w_carry_nxt = at_max & c_WRAP;
                end else if (w_down) begin
                    if (!at_zero || c_WRAP) begin
                        w_next_count = w_dec_val;
                    end
                    w_borrow_nxt = at_zero & c_WRAP;
                end
                // A wrap landing on the win score still locks; its pulse
                // is emitted in the same cycle.
                if (c_WIN_EN && (w_next_count == c_WIN_BCD)) begin
                    w_next_state = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                w_next_state = ST_LOCKED;
            end
            default: begin
                w_next_state = ST_COUNT;
            end
        endcase
    end

    // State register. The prev registers sample even during clear and lock so
    // that an input held across either never produces a late count.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_COUNT;
            r_count    <= '0;
            r_pos_prev <= 1'b0;
            r_neg_prev <= 1'b0;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
        end else begin
            r_pos_prev <= inc_pos;
            r_neg_prev <= inc_neg;
            if (clear) begin
                r_state  <= ST_COUNT;
                r_count  <= '0;
                r_carry  <= 1'b0;
                r_borrow <= 1'b0;
            end else begin
                r_state  <= w_next_state;
                r_count  <= w_next_count;
                r_carry  <= w_carry_nxt;
                r_borrow <= w_borrow_nxt;
            end
        end
    end

    assign count      = r_count;
    assign carry_out  = r_carry;
    assign borrow_out = r_borrow;
    assign win        = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_score_counter_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_counter_bcd
// Description : Self-checking bench for score_counter_bcd. Four instances in
//               different configurations share one stimulus stream; each is
//               compared every cycle against an integer score model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_counter_bcd;

    localparam int NI = 4;
    localparam int C_DIG  [NI] = '{2, 2, 2, 3};
    localparam int C_WRAP [NI] = '{1, 0, 1, 1};
    localparam int C_WIN  [NI] = '{0, 0, 7, 0};
    localparam int C_BLANK[NI] = '{0, 0, 0, 1};
    localparam logic [6:0] C_SEG[10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic clk;
    logic rst_n;
    logic clear;
    logic inc_pos;
    logic inc_neg;

    logic [7:0]  count0, count1, count2;
    logic [11:0] count3;
    logic [13:0] hex0, hex1, hex2;
    logic [20:0] hex3;
    logic [NI-1:0] carry_v, borrow_v, atz_v, atm_v, win_v;

    score_counter_bcd #(.DIGITS(2), .WRAP(1), .WIN_SCORE(0), .BLANK_LZ(0)) u0 (
        .clk(clk), .Reset_n(rst_n), .clear(clear), .inc_pos(inc_pos), .inc_neg(inc_neg),
        .count(count0), .hex(hex0), .carry_out(carry_v[0]), .borrow_out(borrow_v[0]),
        .at_zero(atz_v[0]), .at_max(atm_v[0]), .win(win_v[0]));
    score_counter_bcd #(.DIGITS(2), .WRAP(0), .WIN_SCORE(0), .BLANK_LZ(0)) u1 (
        .clk(clk), .Reset_n(rst_n), .clear(clear), .inc_pos(inc_pos), .inc_neg(inc_neg),
        .count(count1), .hex(hex1), .carry_out(carry_v[1]), .borrow_out(borrow_v[1]),
        .at_zero(atz_v[1]), .at_max(atm_v[1]), .win(win_v[1]));
    score_counter_bcd #(.DIGITS(2), .WRAP(1), .WIN_SCORE(7), .BLANK_LZ(0)) u2 (
        .clk(clk), .Reset_n(rst_n), .clear(clear), .inc_pos(inc_pos), .inc_neg(inc_neg),
        .count(count2), .hex(hex2), .carry_out(carry_v[2]), .borrow_out(borrow_v[2]),
        .at_zero(atz_v[2]), .at_max(atm_v[2]), .win(win_v[2]));
    score_counter_bcd #(.DIGITS(3), .WRAP(1), .WIN_SCORE(0), .BLANK_LZ(1)) u3 (
        .clk(clk), .Reset_n(rst_n), .clear(clear), .inc_pos(inc_pos), .inc_neg(inc_neg),
        .count(count3), .hex(hex3), .carry_out(carry_v[3]), .borrow_out(borrow_v[3]),
        .at_zero(atz_v[3]), .at_max(atm_v[3]), .win(win_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain integer score per instance
    int score [NI];
    bit locked[NI];
    bit ecy   [NI];
    bit ebw   [NI];
    bit pp, np;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int maxv(input int k);
        return (10 ** C_DIG[k]) - 1;
    endfunction

    function automatic logic [63:0] exp_count(input int k);
        logic [63:0] r = '0;
        int v = score[k];
        for (int i = 0; i < C_DIG[k]; i++) begin
            r = r | (64'(v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_hex(input int k);
        logic [63:0] r = '0;
        logic [6:0]  s;
        int v = score[k];
        for (int i = 0; i < C_DIG[k]; i++) begin
            s = C_SEG[v % 10];
            if (C_BLANK[k] != 0 && i > 0 && score[k] < 10 ** i) s = 7'b1111111;
            r = r | (64'(s) << (7 * i));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] get_count(input int k);
        case (k)
            0: return 64'(count0);
            1: return 64'(count1);
            2: return 64'(count2);
            default: return 64'(count3);
        endcase
    endfunction

    function automatic logic [63:0] get_hex(input int k);
        case (k)
            0: return 64'(hex0);
            1: return 64'(hex1);
            2: return 64'(hex2);
            default: return 64'(hex3);
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            score[k] = 0; locked[k] = 0; ecy[k] = 0; ebw[k] = 0;
        end
        pp = 0; np = 0;
    endtask

    task automatic model_step(input bit ip, input bit in_, input bit clr);
        bit rp, rn;
        rp = ip & ~pp;
        rn = in_ & ~np;
        pp = ip;
        np = in_;
        for (int k = 0; k < NI; k++) begin
            ecy[k] = 0;
            ebw[k] = 0;
            if (clr) begin
                score[k]  = 0;
                locked[k] = 0;
            end else if (!locked[k]) begin
                if (rp && !rn) begin
                    if (score[k] == maxv(k)) begin
                        if (C_WRAP[k] != 0) begin score[k] = 0; ecy[k] = 1; end
                    end else score[k] = score[k] + 1;
                end else if (rn && !rp) begin
                    if (score[k] == 0) begin
                        if (C_WRAP[k] != 0) begin score[k] = maxv(k); ebw[k] = 1; end
                    end else score[k] = score[k] - 1;
                end
                if (C_WIN[k] != 0 && score[k] == C_WIN[k]) locked[k] = 1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("u%0d.count", k),  get_count(k), exp_count(k));
            chk($sformatf("u%0d.hex", k),    get_hex(k),   exp_hex(k));
            chk($sformatf("u%0d.carry", k),  64'(carry_v[k]),  64'(ecy[k]));
            chk($sformatf("u%0d.borrow", k), 64'(borrow_v[k]), 64'(ebw[k]));
            chk($sformatf("u%0d.win", k),    64'(win_v[k]),    64'(locked[k]));
            chk($sformatf("u%0d.at_zero", k), 64'(atz_v[k]), 64'(score[k] == 0));
            chk($sformatf("u%0d.at_max", k),  64'(atm_v[k]), 64'(score[k] == maxv(k)));
        end
    endtask

    // Called at a falling edge: drive, take the rising edge, check at the next falling edge.
    task automatic tick(input bit ip, input bit in_, input bit clr);
        inc_pos = ip;
        inc_neg = in_;
        clear   = clr;
        @(posedge clk);
        if (rst_n) model_step(ip, in_, clr);
        @(negedge clk);
        check_all();
    endtask

    task automatic pulse_up(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1, 0, 0);
            tick(0, 0, 0);
        end
    endtask

    task automatic pulse_dn(input int n);
        for (int i = 0; i < n; i++) begin
            tick(0, 1, 0);
            tick(0, 0, 0);
        end
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("async.count0", get_count(0), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        clear   = 1'b0;
        inc_pos = 1'b0;
        inc_neg = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        chk("rst.hex0_d0", 64'(hex0[6:0]), 64'(7'b1000000));
        chk("rst.at_zero", 64'(atz_v[0]), 64'h1);
        rst_n = 1'b1;

        // Edge counting
        pulse_up(12);
        chk("pulse12.count0", get_count(0), 64'h12);
        chk("win7.count2", get_count(2), 64'h07);
        chk("win7.level", 64'(win_v[2]), 64'h1);
        for (int i = 0; i < 10; i++) tick(1, 0, 0);
        tick(0, 0, 0);
        chk("hold.count0", get_count(0), 64'h13);

        // Simultaneous edges cancel
        tick(1, 1, 0);
        tick(0, 0, 0);
        chk("simul.count0", get_count(0), 64'h13);
        pulse_dn(3);
        chk("down.count0", get_count(0), 64'h10);
        pulse_dn(1);
        chk("digit_borrow.count0", get_count(0), 64'h09);
        chk("win.held.count2", get_count(2), 64'h07);

        // Clear releases the lock
        tick(0, 0, 1);
        chk("clear.count2", get_count(2), 64'h0);
        chk("clear.win2", 64'(win_v[2]), 64'h0);
        pulse_up(1);
        chk("after_clear.count2", get_count(2), 64'h01);

        // Wrap / saturate at the top and bottom
        tick(0, 0, 1);
        pulse_up(99);
        chk("top.count0", get_count(0), 64'h99);
        chk("top.count1", get_count(1), 64'h99);
        tick(1, 0, 0);
        chk("wrap.count0", get_count(0), 64'h00);
        chk("wrap.carry0", 64'(carry_v[0]), 64'h1);
        chk("sat.count1", get_count(1), 64'h99);
        chk("sat.carry1", 64'(carry_v[1]), 64'h0);
        tick(0, 0, 0);
        chk("carry.one_cycle", 64'(carry_v[0]), 64'h0);
        tick(0, 0, 1);
        tick(0, 1, 0);
        chk("wrapdn.count0", get_count(0), 64'h99);
        chk("wrapdn.borrow0", 64'(borrow_v[0]), 64'h1);
        chk("satdn.count1", get_count(1), 64'h00);
        chk("satdn.borrow1", 64'(borrow_v[1]), 64'h0);
        tick(0, 0, 0);
        chk("borrow.one_cycle", 64'(borrow_v[0]), 64'h0);

        // Leading-zero blanking on the 3-digit instance
        tick(0, 0, 1);
        pulse_up(5);
        chk("blank.005", get_hex(3), 64'({7'b1111111, 7'b1111111, 7'b0010010}));
        pulse_up(100);
        chk("blank.105.count", get_count(3), 64'h105);
        chk("blank.105.d1", 64'(hex3[13:7]), 64'(7'b1000000));

        // Reset while an input is held high: counts once after release
        inc_pos = 1'b1;
        async_reset();
        tick(1, 0, 0);
        tick(1, 0, 0);
        chk("held_thru_reset.count0", get_count(0), 64'h01);
        tick(0, 0, 0);

        // Randomised phases biased up or down so boundaries get exercised
        for (int ph = 0; ph < 12; ph++) begin
            for (int c = 0; c < 300; c++) begin
                bit up_bias;
                up_bias = (ph % 2) == 0;
                if ($urandom_range(0, 249) == 0) begin
                    async_reset();
                end else begin
                    tick(up_bias ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0),
                         up_bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0),
                         $urandom_range(0, 99) == 0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
